// File: rtl/hw_rsp_pkg.sv
// Shared types and header layout for the SDM mailbox response parser.
package hw_rsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    localparam int HDR_ID_LSB  = 24;
    localparam int HDR_LEN_LSB = 12;
    localparam int HDR_ERR_LSB = 0;

    localparam int ERR_WIDTH = 11;
    localparam int LEN_WIDTH = 11;

    function automatic int num_ids(input int id_width);
        return 1 << id_width;
    endfunction

endpackage

// File: rtl/hw_rsp_if.sv
// Valid/ready response word channel from the mailbox into the parser.
interface hw_rsp_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_valid;
    logic                  rsp_ready;

    modport master (output rsp_data, output rsp_valid, input rsp_ready);
    modport slave  (input rsp_data, input rsp_valid, output rsp_ready);
endinterface

// File: rtl/hw_rsp_bank.sv
// Per-ID result register file: one write port, one asynchronous read port.
module hw_rsp_bank
    import hw_rsp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [ID_WIDTH-1:0]   wr_id_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ERR_WIDTH-1:0]  wr_err_i,
    input  logic [ID_WIDTH-1:0]   rd_id_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [ERR_WIDTH-1:0]  rd_err_o
);
    localparam int NUM_IDS = num_ids(ID_WIDTH);

    logic [DATA_WIDTH-1:0] data_q [NUM_IDS];
    logic [ERR_WIDTH-1:0]  err_q  [NUM_IDS];

    // NOTE: the bank is small and must read back 0 after reset, so it is built
    // from resettable flops rather than a RAM macro.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                data_q[i] <= '0;
                err_q[i]  <= '0;
            end
        end else if (we_i) begin
            data_q[wr_id_i] <= wr_data_i;
            err_q[wr_id_i]  <= wr_err_i;
        end
    end

    assign rd_data_o = data_q[rd_id_i];
    assign rd_err_o  = err_q[rd_id_i];

endmodule

// File: rtl/hw_response_parser.sv
// Mailbox response parser: header decode, pending-ID tracking, result bank.
// Optional response timeout watchdog enabled by defining HW_RSP_TIMEOUT_EN.
module hw_response_parser
    import hw_rsp_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    hw_rsp_if.slave                       rsp,
    input  logic                          cmd_issue_i,
    input  logic [ID_WIDTH-1:0]           cmd_id_i,
    input  logic                          clr_i,
    input  logic [ID_WIDTH-1:0]           rd_id_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic [ERR_WIDTH-1:0]          rd_err_o,
    output logic [num_ids(ID_WIDTH)-1:0]  result_valid_o,
    output logic [num_ids(ID_WIDTH)-1:0]  pending_o,
    output logic                          done_pulse_o,
    output logic [ID_WIDTH-1:0]           done_id_o,
    output logic                          unexpected_o,
    output logic                          len_err_o,
    output logic                          timeout_o
);
    state_t                state;
    logic                  rdy_q;
    logic                  owed_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ERR_WIDTH-1:0]  err_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [DATA_WIDTH-1:0] payload_q;

    logic [ID_WIDTH-1:0]   hdr_id;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic [ERR_WIDTH-1:0]  hdr_err;
    logic                  accept, hdr_acc, hdr_pend, commit;
    logic                  go_commit, unexp_set, len_err_set, timeout_hit;
    logic [ID_WIDTH-1:0]   commit_id;

    assign hdr_id  = rsp.rsp_data[HDR_ID_LSB  +: ID_WIDTH];
    assign hdr_len = rsp.rsp_data[HDR_LEN_LSB +: LEN_WIDTH];
    assign hdr_err = rsp.rsp_data[HDR_ERR_LSB +: ERR_WIDTH];

    assign rsp.rsp_ready = rdy_q;
    assign accept        = rsp.rsp_valid & rdy_q;
    assign hdr_acc       = accept && (state == ST_IDLE);
    assign hdr_pend      = pending_o[hdr_id];
    assign commit        = (state == ST_COMMIT);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        go_commit   = 1'b0;
        unexp_set   = 1'b0;
        len_err_set = 1'b0;
        commit_id   = id_q;
        unique case (state)
            ST_IDLE: begin
                commit_id = hdr_id;
                if (hdr_acc) begin
                    unexp_set   = !hdr_pend;
                    go_commit   = hdr_pend && (hdr_len == '0);
                    len_err_set = go_commit && (hdr_err == '0);
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    go_commit   = (rem_q == LEN_WIDTH'(1));
                    len_err_set = !go_commit && (err_q == '0);
                end
            end
            ST_DRAIN:  go_commit = accept && owed_q && (rem_q == LEN_WIDTH'(1));
            default:   go_commit = 1'b0;
        endcase
    end

    // Control FSM; ready and done are registered. Ready comes up one cycle
    // after reset release so all outputs read 0 while in reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            rdy_q        <= 1'b0;
            owed_q       <= 1'b0;
            id_q         <= '0;
            err_q        <= '0;
            rem_q        <= '0;
            payload_q    <= '0;
            done_pulse_o <= 1'b0;
            done_id_o    <= '0;
        end else begin
            rdy_q        <= 1'b1;
            done_pulse_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        id_q      <= hdr_id;
                        err_q     <= hdr_err;
                        rem_q     <= hdr_len;
                        payload_q <= '0;
                        owed_q    <= hdr_pend;
                        if (!hdr_pend) begin
                            if (hdr_len != '0) state <= ST_DRAIN;
                        end else if (hdr_len != '0) begin
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        payload_q <= rsp.rsp_data;
                        rem_q     <= rem_q - LEN_WIDTH'(1);
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        rem_q <= rem_q - LEN_WIDTH'(1);
                        if (rem_q == LEN_WIDTH'(1)) state <= ST_IDLE;
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
            // Overrides the per-state next state on the way into COMMIT.
            if (go_commit) begin
                state        <= ST_COMMIT;
                rdy_q        <= 1'b0;
                done_pulse_o <= 1'b1;
                done_id_o    <= commit_id;
            end
        end
    end

    hw_rsp_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_bank (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .we_i      (commit),
        .wr_id_i   (id_q),
        .wr_data_i (payload_q),
        .wr_err_i  (err_q),
        .rd_id_i   (rd_id_i),
        .rd_data_o (rd_data_o),
        .rd_err_o  (rd_err_o)
    );

    // Later assignments win: sets beat clears, and an issue beats commit/timeout.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_valid_o <= '0;
            pending_o      <= '0;
            unexpected_o   <= 1'b0;
            len_err_o      <= 1'b0;
        end else begin
            if (clr_i) begin
                result_valid_o <= '0;
                unexpected_o   <= 1'b0;
                len_err_o      <= 1'b0;
            end
            if (commit)      result_valid_o[id_q] <= 1'b1;
            if (unexp_set)   unexpected_o         <= 1'b1;
            if (len_err_set) len_err_o            <= 1'b1;
            if (timeout_hit) pending_o            <= '0;
            if (commit)      pending_o[id_q]      <= 1'b0;
            if (cmd_issue_i) pending_o[cmd_id_i]  <= 1'b1;
        end
    end

`ifdef HW_RSP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             to_cnt_rst;

    assign to_cnt_rst  = hdr_acc || (pending_o == '0);
    assign timeout_hit = !to_cnt_rst && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q  <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (to_cnt_rst || timeout_hit) to_cnt_q <= '0;
            else                           to_cnt_q <= to_cnt_q + CNT_W'(1);
            if (clr_i)       timeout_o <= 1'b0;
            if (timeout_hit) timeout_o <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_hw_response_parser.sv
// Scoreboard bench for hw_response_parser; honours HW_RSP_TIMEOUT_EN if defined.
`timescale 1ns/1ps
module tb_hw_response_parser;

    localparam int DW = 32;
    localparam int IW = 4;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [10:0]   err;
        logic          pend;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_issue, clr;
    logic [IW-1:0] cmd_id, rd_id;
    logic [DW-1:0] rd_data;
    logic [10:0]   rd_err;
    logic [15:0]   result_valid, pending;
    logic          done_pulse, unexpected, len_err, timeout;
    logic [IW-1:0] done_id;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    hw_rsp_if #(.DATA_WIDTH(DW)) rsp_bus ();

    hw_response_parser #(
        .DATA_WIDTH     (DW),
        .ID_WIDTH       (IW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .rsp            (rsp_bus),
        .cmd_issue_i    (cmd_issue),
        .cmd_id_i       (cmd_id),
        .clr_i          (clr),
        .rd_id_i        (rd_id),
        .rd_data_o      (rd_data),
        .rd_err_o       (rd_err),
        .result_valid_o (result_valid),
        .pending_o      (pending),
        .done_pulse_o   (done_pulse),
        .done_id_o      (done_id),
        .unexpected_o   (unexpected),
        .len_err_o      (len_err),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [IW-1:0] id);
        cmd_issue = 1'b1;
        cmd_id    = id;
        @(posedge clk);
        #1;
        cmd_issue = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Presents one word, waits (bounded) for ready, returns just after the accepting edge.
    task automatic send_word(input logic [DW-1:0] w);
        int budget = 20;
        rsp_bus.rsp_data  = w;
        rsp_bus.rsp_valid = 1'b1;
        @(negedge clk);
        while (!rsp_bus.rsp_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("ready_wait", 64'(rsp_bus.rsp_ready), 64'd1);
        @(posedge clk);
        #1;
        rsp_bus.rsp_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({rsp_bus.rsp_ready, done_pulse, unexpected, len_err, timeout}), 64'd0);
        check({tag, "_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_pending"}, 64'(pending), 64'd0);
        check({tag, "_rd"}, {21'd0, rd_err, rd_data}, 64'd0);
    endtask

    // Commit monitor: pops the scoreboard on each done pulse, then reads the bank back.
    initial begin : monitor
        exp_t e;
        rd_id = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done_pulse === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(done_id), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("done_id", 64'(done_id), 64'(e.id));
                    rd_id = e.id;
                    @(negedge clk);
                    check("rd_data", 64'(rd_data), 64'(e.data));
                    check("rd_err", 64'(rd_err), 64'(e.err));
                    check("result_valid", 64'(result_valid[e.id]), 64'd1);
                    check("pending_after", 64'(pending[e.id]), 64'(e.pend));
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // NOTE: stimulus is driven with blocking assignments just after the
        // clock edge so the DUT samples it cleanly on the next edge.
        rst_n             = 1'b0;
        cmd_issue         = 1'b0;
        cmd_id            = '0;
        clr               = 1'b0;
        rsp_bus.rsp_valid = 1'b0;
        rsp_bus.rsp_data  = '0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // Single-word response for ID2.
        issue(4'd2);
        sb.push_back('{id: 4'd2, data: 32'h1A80, err: 11'd0, pend: 1'b0});
        send_word(32'h0200_1000);
        send_word(32'h0000_1A80);
        @(negedge clk);
        check("commit_ready", 64'(rsp_bus.rsp_ready), 64'd0);
        check("commit_done_id2", 64'(done_pulse), 64'd1);
        cycles(3);

        // Zero-length response carrying an error code.
        issue(4'd3);
        sb.push_back('{id: 4'd3, data: 32'h0, err: 11'h003, pend: 1'b0});
        send_word(32'h0300_0003);
        @(negedge clk);
        check("commit_done_id3", 64'(done_pulse), 64'd1);
        cycles(3);
        check("len_err_clean", 64'(len_err), 64'd0);

        // Response for an ID that was never issued: drained, not committed.
        send_word(32'h0500_2000);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        cycles(3);
        check("unexpected_set", 64'(unexpected), 64'd1);
        check("unexpected_no_valid", 64'(result_valid[5]), 64'd0);

        // Over-long response: first word kept, rest drained.
        issue(4'd4);
        sb.push_back('{id: 4'd4, data: 32'hA, err: 11'd0, pend: 1'b0});
        send_word(32'h0400_3000);
        send_word(32'hA);
        send_word(32'hB);
        send_word(32'hC);
        @(negedge clk);
        check("commit_after_third", 64'(done_pulse), 64'd1);
        cycles(3);
        check("len_err_set", 64'(len_err), 64'd1);
        pulse_clr();
        check("clr_flags", 64'({unexpected, len_err, timeout}), 64'd0);
        check("clr_valid", 64'(result_valid), 64'd0);

        // Maximum length drains without counter wrap.
        issue(4'd1);
        sb.push_back('{id: 4'd1, data: 32'hBEEF, err: 11'd0, pend: 1'b0});
        send_word(32'h017F_F000);
        send_word(32'hBEEF);
        for (int i = 0; i < 2045; i++) send_word(32'(i));
        check("max_len_no_early", 64'(done_pulse), 64'd0);
        send_word(32'hFFFF_FFFF);
        @(negedge clk);
        check("max_len_commit", 64'(done_pulse), 64'd1);
        cycles(3);
        check("max_len_len_err", 64'(len_err), 64'd1);
        pulse_clr();

        // Timeout watchdog: ID6 issued, no response.
        issue(4'd6);
        repeat (100) @(negedge clk);
        check("timeout_not_early", 64'(timeout), 64'd0);
        @(negedge clk);
`ifdef HW_RSP_TIMEOUT_EN
        check("timeout_set", 64'(timeout), 64'd1);
        check("timeout_pending", 64'(pending), 64'd0);
        cycles(1);
        pulse_clr();
`else
        check("timeout_off", 64'(timeout), 64'd0);
        check("timeout_off_pend", 64'(pending[6]), 64'd1);
        cycles(1);
        sb.push_back('{id: 4'd6, data: 32'h66, err: 11'd0, pend: 1'b0});
        send_word(32'h0600_1000);
        send_word(32'h66);
        cycles(3);
`endif

        // Reset asserted while ID7 is in PAYLOAD.
        issue(4'd7);
        send_word(32'h0700_2000);
        rst_n = 1'b0;
        #2;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        issue(4'd7);
        sb.push_back('{id: 4'd7, data: 32'h1234_5678, err: 11'h005, pend: 1'b0});
        send_word(32'h0700_1005);
        send_word(32'h1234_5678);
        cycles(3);
        check("id7_len_err", 64'(len_err), 64'd0);

        // Re-issue and clear in the COMMIT cycle: both sets win.
        issue(4'd8);
        sb.push_back('{id: 4'd8, data: 32'h0, err: 11'h001, pend: 1'b1});
        send_word(32'h0800_0001);
        cmd_issue = 1'b1;
        cmd_id    = 4'd8;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        cmd_issue = 1'b0;
        clr       = 1'b0;
        cycles(3);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
